// File: rtl/alu_pipe.sv
// Two-stage pipelined Y86 execute ALU with valid/ready handshake and {ZF,SF,OF} register.
// Optional sticky overflow flag (clr_ovf/sticky_ovf) when ALU_STICKY_OVF_EN is defined.
module alu_pipe #(
  parameter int unsigned WIDTH = 64,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic [2:0]       cc
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic             clr_ovf,
  output logic             sticky_ovf
`endif
);

  localparam int unsigned Msb = WIDTH - 1;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpXor = 3'b011,
    OpOr  = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpSar = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_set_cc;
  logic             s2_set_cc;

  logic             adv2;
  logic             accept;
  logic             retire;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] res;
  logic             ovf;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;
  assign amt      = s1_b[SHW-1:0];

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (s1_op)
      OpAdd: begin
        res = s1_a + s1_b;
        ovf = (s1_a[Msb] == s1_b[Msb]) && (res[Msb] != s1_a[Msb]);
      end
      OpSub: begin
        res = s1_a - s1_b;
        ovf = (s1_a[Msb] != s1_b[Msb]) && (res[Msb] != s1_a[Msb]);
      end
      OpAnd: res = s1_a & s1_b;
      OpXor: res = s1_a ^ s1_b;
      OpOr:  res = s1_a | s1_b;
      OpShl: res = s1_a << amt;
      OpShr: res = s1_a >> amt;
      OpSar: res = $signed(s1_a) >>> amt;
      default: res = '0;
    endcase
  end

  // S1 empties whenever it can hand its op to S2 and nothing new arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OpAdd;
      s1_set_cc <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_op     <= op_e'(op);
        s1_set_cc <= set_cc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
      s2_set_cc <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out       <= res;
        overflow  <= ovf;
        s2_set_cc <= s1_set_cc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc <= 3'b100;
    end else if (retire && s2_set_cc) begin
      cc <= {out == '0, out[Msb], overflow};
    end
  end

`ifdef ALU_STICKY_OVF_EN
  // Set has priority so an overflow retiring alongside a clear is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
    end else if (retire && overflow) begin
      sticky_ovf <= 1'b1;
    end else if (clr_ovf) begin
      sticky_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: 64-bit instance with random and directed traffic,
// plus an 8-bit instance for narrow overflow and the optional sticky flag.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [2:0]  op = '0;
  logic        set_cc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out;
  logic        overflow;
  logic [2:0]  cc;

  logic        iv8 = 1'b0;
  logic        ir8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [2:0]  op8 = '0;
  logic        sc8 = 1'b0;
  logic        ov8_valid;
  logic [7:0]  out8;
  logic        ovf8;
  logic [2:0]  cc8;
`ifdef ALU_STICKY_OVF_EN
  logic        clr64 = 1'b0;
  logic        sticky64;
  logic        clr8 = 1'b0;
  logic        sticky8;
`endif

  alu_pipe #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .set_cc(set_cc), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .overflow(overflow), .cc(cc)
`ifdef ALU_STICKY_OVF_EN
    , .clr_ovf(clr64), .sticky_ovf(sticky64)
`endif
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
    .set_cc(sc8), .out_valid(ov8_valid), .out_ready(1'b1), .out(out8),
    .overflow(ovf8), .cc(cc8)
`ifdef ALU_STICKY_OVF_EN
    , .clr_ovf(clr8), .sticky_ovf(sticky8)
`endif
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] r;
    logic        v;
    logic        sc;
  } exp_t;

  // Reference: signed arithmetic done wide; overflow means the true result does not fit.
  function automatic exp_t model(input logic [63:0] xa, input logic [63:0] xb,
                                 input logic [2:0] xop, input logic xsc);
    exp_t e;
    logic signed [65:0] wide;
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic [63:0] ones;
    int amt;
    ones = '1;
    amt = int'(xb[5:0]);
    sa = $signed({{2{xa[63]}}, xa});
    sb = $signed({{2{xb[63]}}, xb});
    wide = '0;
    e.v = 1'b0;
    e.sc = xsc;
    case (xop)
      3'd0: wide = sa + sb;
      3'd1: wide = sa - sb;
      default: wide = '0;
    endcase
    case (xop)
      3'd0, 3'd1: begin
        e.r = wide[63:0];
        e.v = (wide != $signed({{2{wide[63]}}, wide[63:0]}));
      end
      3'd2: e.r = xa & xb;
      3'd3: e.r = xa ^ xb;
      3'd4: e.r = xa | xb;
      3'd5: e.r = xa << amt;
      3'd6: e.r = xa >> amt;
      default: e.r = (xa >> amt) | (xa[63] ? ~(ones >> amt) : 64'd0);
    endcase
    return e;
  endfunction

  exp_t        q[$];
  logic [2:0]  cc_m = 3'b100;
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] out_prev = '0;
  logic        ovf_prev = 1'b0;

  // Sampled at negedge: inputs are stable, the next posedge decides accept/retire.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("cc", {61'd0, cc}, {61'd0, cc_m});
      if (stall_prev) begin
        check("stall_out", out, out_prev);
        check("stall_ovf", {63'd0, overflow}, {63'd0, ovf_prev});
        check("stall_valid", {63'd0, out_valid}, 64'd1);
      end
      if (rst) begin
        q.delete();
        cc_m = 3'b100;
        stall_prev = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_retire: got out %h expected no result", out);
          end else begin
            e = q.pop_front();
            check("out", out, e.r);
            check("ovf", {63'd0, overflow}, {63'd0, e.v});
            if (e.sc) cc_m = {e.r == 64'd0, e.r[63], e.v};
          end
        end
        if (in_valid && in_ready) q.push_back(model(a, b, op, set_cc));
        stall_prev = out_valid && !out_ready;
        out_prev = out;
        ovf_prev = overflow;
      end
    end
  end

  bit rnd_rdy = 1'b0;
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Caller is at posedge+2; returns at posedge+2 of the accepting edge.
  task automatic send(input logic [63:0] xa, input logic [63:0] xb, input logic [2:0] xop,
                      input logic xsc);
    int n;
    a = xa;
    b = xb;
    op = xop;
    set_cc = xsc;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
        break;
      end
    end
    @(posedge clk);
    #2 in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [63:0] xa, input logic [63:0] xb,
                          input logic [2:0] xop, input logic xsc, input logic [63:0] er,
                          input logic ev, input logic [2:0] ecc);
    int n;
    send(xa, xb, xop, xsc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check({name, "_latency"}, 64'(n), 64'd2);
    check({name, "_out"}, out, er);
    check({name, "_ovf"}, {63'd0, overflow}, {63'd0, ev});
    @(negedge clk);
    check({name, "_cc"}, {61'd0, cc}, {61'd0, ecc});
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'd0;
      3: return '1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500us");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out", out, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_cc", {61'd0, cc}, 64'd4);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #2;

    directed("add5_7", 64'd5, 64'd7, 3'd0, 1'b1, 64'd12, 1'b0, 3'b000);
    directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 1'b1,
             64'h8000_0000_0000_0000, 1'b1, 3'b011);
    directed("sub_zero", 64'd3, 64'd3, 3'd1, 1'b1, 64'd0, 1'b0, 3'b100);
    directed("shl", 64'h8000_0000_0000_00F0, 64'h104, 3'd5, 1'b0,
             64'h0000_0000_0000_0F00, 1'b0, 3'b100);
    directed("shr", 64'h8000_0000_0000_00F0, 64'h104, 3'd6, 1'b0,
             64'h0800_0000_0000_000F, 1'b0, 3'b100);
    directed("sar", 64'h8000_0000_0000_00F0, 64'h104, 3'd7, 1'b0,
             64'hF800_0000_0000_000F, 1'b0, 3'b100);
    directed("sar_amt0", 64'h8000_0000_0000_00F0, 64'h40, 3'd7, 1'b0,
             64'h8000_0000_0000_00F0, 1'b0, 3'b100);

    // Back-to-back stream with a downstream stall in the middle.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(64'(i * 100), 64'(i + 1), 3'd0, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #2;
      end
      send(rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    // Reset with two ops in flight.
    directed("pre_rst", 64'd1, 64'd1, 3'd0, 1'b1, 64'd2, 1'b0, 3'b000);
    out_ready = 1'b0;
    send(64'd0, 64'd0, 3'd0, 1'b1);
    send(64'd9, 64'd9, 3'd1, 1'b1);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_cc", {61'd0, cc}, 64'd4);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    repeat (2) @(negedge clk);
    check("flush_no_retire", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #2;
    directed("post_rst", 64'd1, 64'd2, 3'd0, 1'b1, 64'd3, 1'b0, 3'b000);
    drain();

    // Narrow instance: 8-bit overflow and sticky flag.
    a8 = 8'h7F;
    b8 = 8'h01;
    op8 = 3'd0;
    sc8 = 1'b1;
    iv8 = 1'b1;
    @(posedge clk);
    #2 iv8 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ov8_valid) break;
    end
    check("w8_valid", {63'd0, ov8_valid}, 64'd1);
    check("w8_out", {56'd0, out8}, 64'h80);
    check("w8_ovf", {63'd0, ovf8}, 64'd1);
    @(negedge clk);
    check("w8_cc", {61'd0, cc8}, 64'd3);
`ifdef ALU_STICKY_OVF_EN
    check("sticky_set", {63'd0, sticky8}, 64'd1);
    repeat (3) @(negedge clk);
    check("sticky_hold", {63'd0, sticky8}, 64'd1);
    @(posedge clk);
    #2 clr8 = 1'b1;
    @(posedge clk);
    #2 clr8 = 1'b0;
    @(negedge clk);
    check("sticky_clr", {63'd0, sticky8}, 64'd0);
    @(posedge clk);
    #2 iv8 = 1'b1;
    @(posedge clk);
    #2 iv8 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ov8_valid) break;
    end
    clr8 = 1'b1;
    @(posedge clk);
    #2 clr8 = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", {63'd0, sticky8}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, 2-stage pipelined successor to the 64-bit combinational ALU, with an 8-operation set, valid/ready handshake, and a condition-code register (ZF, SF, OF) for the Y86 execute stage.
- Sits between decode and memory stages.
- Backpressure from downstream stalls the pipe without losing or duplicating operations.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block accepts operation this cycle
- a  input  WIDTH  operand A (signed)
- b  input  WIDTH  operand B (signed); shift amount is b[SHW-1:0]
- op  input  3  000 ADD, 001 SUB (a-b), 010 AND, 011 XOR, 100 OR, 101 SHL, 110 SHR logical, 111 SAR arithmetic
- set_cc  input  1  update condition codes when this operation retires
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  result
- overflow  output  1  signed overflow of this result
- cc  output  3  {ZF, SF, OF} register

Behaviour:
- Interface: one clock and one reset. Reset is synchronous and active-high. Clock port is clk and reset port is rst.
- Reset values: out_valid=0, out=0, overflow=0, cc=3'b100 (ZF=1, SF=0, OF=0), internal s1_valid=0. in_ready=1 the cycle after reset deasserts.
- Stage 1 (S1): registers a, b, op, set_cc on accept = in_valid && in_ready.
- Stage 2 (S2): computes from the S1 registers and registers out, overflow, out_valid.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput is 1 op/cycle.
- Advance rule: adv2 = !out_valid || out_ready. in_ready = !s1_valid || adv2 (combinational, no in_valid dependency).
- S2 loads when adv2.
  - out_valid_next = s1_valid.
  - If s1_valid=0 on an advance, out_valid drops and out holds its last value.
- Stall: out_valid && !out_ready holds out, overflow, and the S1 contents stable. in_ready=0 once S1 is also full.
- Arithmetic is modulo 2^WIDTH.
  - ADD OF = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB OF = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - AND/XOR/OR/shifts: OF=0.
- Shifts: amount = b[SHW-1:0] only (0..WIDTH-1), upper b bits ignored. Amount 0 returns a unchanged. SAR replicates a[MSB].
- CC update on retire (out_valid && out_ready) of an op whose set_cc=1:
  - ZF = (out==0), SF = out[MSB], OF = overflow.
  - cc changes the cycle after retire.
  - Ops with set_cc=0 leave cc unchanged.
- Simultaneous retire and accept in the same cycle is legal. No bubble is inserted.
- rst mid-operation: both stages are flushed and in-flight ops are discarded without cc update. rst dominates in_valid in the same cycle.
- No X propagation: out is driven from registers only.

Optional Feature:
- Macro ALU_STICKY_OVF_EN.
- When defined:
  - Adds input clr_ovf (1) and output sticky_ovf (1), reset 0.
  - sticky_ovf sets the cycle after any retire with overflow=1, regardless of set_cc.
  - clr_ovf clears it; a simultaneous set wins over clr.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan (WIDTH=64 unless noted):
1. Reset then ADD a=5, b=7, set_cc=1, out_ready=1 → out_valid 2 cycles after accept, out=12, overflow=0; next cycle cc=3'b000.
2. ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 → out=0x8000_0000_0000_0000, overflow=1, cc=3'b011. SUB a=3, b=3 → out=0, cc=3'b100.
3. Shifts with a=0x8000_0000_0000_00F0, b=0x104 (amount 4):
   - SHL → 0x0000_0000_0000_0F00
   - SHR → 0x0800_0000_0000_000F
   - SAR → 0xF800_0000_0000_000F
4. Back-to-back stream of 4 ADDs, out_ready low for 3 cycles mid-stream:
   - in_ready drops once both stages are full.
   - All 4 results emerge in order, none dropped or duplicated, out stable while stalled.
5. rst asserted while 2 ops are in flight → next cycle out_valid=0, cc=3'b100, no retire observed. A fresh op afterwards completes normally.
6. WIDTH=8: ADD 0x7F+0x01 → out=0x80, OF=1. With ALU_STICKY_OVF_EN: sticky_ovf=1 until clr_ovf pulse, then 0; same-cycle overflow and clr_ovf leaves it 1.
